// File: rtl/sram_ctrl.sv
// Request-side SRAM sequencer: single/burst read and write over valid/ready,
// one SRAM access per clock, read data returned after a fixed pipeline latency.
module sram_ctrl #(
  parameter int AW     = 19,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [7:0]    req_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          csn,
  output logic          wen,
  output logic [AW-1:0] a,
  output logic [DW-1:0] din,
  input  logic [DW-1:0] dout
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            csn_q, csn_d;
  logic            wen_q, wen_d;
  logic [AW-1:0]   a_q, a_d;
  logic [DW-1:0]   din_q, din_d;
  logic [RD_LAT:0] pipe_q, pipe_d;
  logic [DW-1:0]   rd_data_q;

  // pipe_q[i] marks a read that was on the pins i+1 cycles ago; the top bit is rd_valid.
  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = csn_q & ~wen_q;
    for (int i = 1; i <= RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    csn_d     = 1'b0;
    wen_d     = 1'b0;
    a_d       = a_q;
    din_d     = din_q;
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          cnt_d   = req_len;
          state_d = req_we ? WRITE : READ;
        end
      end
      WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          csn_d  = 1'b1;
          wen_d  = 1'b1;
          a_d    = addr_q;
          din_d  = wr_data;
          addr_d = addr_q + AW'(1);
          cnt_d  = cnt_q - 8'd1;
          if (cnt_q == 8'd0) state_d = IDLE;
        end
      end
      READ: begin
        csn_d  = 1'b1;
        a_d    = addr_q;
        addr_d = addr_q + AW'(1);
        cnt_d  = cnt_q - 8'd1;
        if (cnt_q == 8'd0) state_d = DRAIN;
      end
      DRAIN: begin
        // Leave as the last beat retires so busy drops the cycle after its rd_valid.
        if (pipe_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      csn_q     <= 1'b0;
      wen_q     <= 1'b0;
      a_q       <= '0;
      din_q     <= '0;
      pipe_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      csn_q   <= csn_d;
      wen_q   <= wen_d;
      a_q     <= a_d;
      din_q   <= din_d;
      pipe_q  <= pipe_d;
      if (pipe_d[RD_LAT]) rd_data_q <= dout;
    end
  end

  assign csn      = csn_q;
  assign wen      = wen_q;
  assign a        = a_q;
  assign din      = din_q;
  assign rd_valid = pipe_q[RD_LAT];
  assign rd_data  = rd_data_q;
  assign busy     = (state_q != IDLE) || (|pipe_q) || csn_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural SRAM (RD_LAT=1) and pin monitor.
module tb_sram_ctrl;
  localparam int AW = 19;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          busy, csn, wen;
  logic [AW-1:0] a;
  logic [DW-1:0] din;
  logic [DW-1:0] dout = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  sram_ctrl #(.AW(AW), .DW(DW), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
    .csn(csn), .wen(wen), .a(a), .din(din), .dout(dout)
  );

  always #5 clk = ~clk;

  // SRAM model: read data appears one cycle after the access.
  logic [DW-1:0] mem [int unsigned];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (csn && wen) mem[int'(a)] = din;
    if (csn && !wen) dout <= mem.exists(int'(a)) ? mem[int'(a)] : '0;
  end

  logic [AW-1:0] a_log[$];
  logic          wen_log[$];
  logic [DW-1:0] din_log[$];
  int            csn_cyc[$];
  logic [DW-1:0] rd_log[$];
  int            rd_cyc[$];
  int            acc_cyc[$];
  int            rdylow_cyc[$];
  int            fall_cyc = -1;
  logic          busy_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (csn) begin
        a_log.push_back(a); wen_log.push_back(wen); din_log.push_back(din); csn_cyc.push_back(cyc);
      end
      if (rd_valid) begin
        rd_log.push_back(rd_data); rd_cyc.push_back(cyc);
      end
      if (req_valid && req_ready) acc_cyc.push_back(cyc);
      if (req_valid && !req_ready) rdylow_cyc.push_back(cyc);
      if (busy_prev && !busy) fall_cyc = cyc;
      busy_prev = busy;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    a_log.delete(); wen_log.delete(); din_log.delete(); csn_cyc.delete();
    rd_log.delete(); rd_cyc.delete(); acc_cyc.delete(); rdylow_cyc.delete();
    fall_cyc = -1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue_req(input logic we, input logic [AW-1:0] ad, input logic [7:0] len, input bit hold);
    logic r;
    int n;
    req_valid = 1'b1; req_we = we; req_addr = ad; req_len = len;
    n = 0;
    do begin
      @(negedge clk); r = req_ready;
      @(posedge clk); #1; n++;
    end while (!r && n < 50);
    chk("req_handshake", {31'd0, r}, 32'd1);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wr_beat(input logic [DW-1:0] d);
    logic r;
    int n;
    wr_valid = 1'b1; wr_data = d;
    n = 0;
    do begin
      @(negedge clk); r = wr_ready;
      @(posedge clk); #1; n++;
    end while (!r && n < 50);
    chk("wr_handshake", {31'd0, r}, 32'd1);
    wr_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0;
    mem[32'h7FFFE] = 16'h1111; mem[32'h7FFFF] = 16'h2222;
    mem[32'h00000] = 16'h3333; mem[32'h00001] = 16'h4444;
    for (int i = 0; i < 8; i++) mem[32'h200 + i] = 16'h5A00 + 16'(i);

    // reset state
    wait_cycles(3);
    @(negedge clk);
    chk("rst_csn", {31'd0, csn}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_a", 32'(a), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    // single write
    clear_logs();
    @(posedge clk); #1;
    issue_req(1'b1, 19'h00005, 8'd0, 1'b0);
    wr_beat(16'hA5A5);
    wait_cycles(4);
    chk("w1_pulses", a_log.size(), 32'd1);
    chk("w1_a", 32'(a_log[0]), 32'h5);
    chk("w1_wen", {31'd0, wen_log[0]}, 32'd1);
    chk("w1_din", 32'(din_log[0]), 32'hA5A5);
    @(negedge clk);
    chk("w1_req_ready", {31'd0, req_ready}, 32'd1);
    chk("w1_busy", {31'd0, busy}, 32'd0);

    // single read
    clear_logs();
    @(posedge clk); #1;
    issue_req(1'b0, 19'h00005, 8'd0, 1'b0);
    wait_cycles(6);
    chk("r1_pulses", a_log.size(), 32'd1);
    chk("r1_a", 32'(a_log[0]), 32'h5);
    chk("r1_wen", {31'd0, wen_log[0]}, 32'd0);
    chk("r1_rd_count", rd_log.size(), 32'd1);
    chk("r1_rd_data", 32'(rd_log[0]), 32'hA5A5);
    chk("r1_latency", 32'(rd_cyc[0] - csn_cyc[0]), 32'd2);

    // burst read with address wrap
    clear_logs();
    issue_req(1'b0, 19'h7FFFE, 8'd3, 1'b0);
    wait_cycles(10);
    chk("br_pulses", a_log.size(), 32'd4);
    chk("br_a0", 32'(a_log[0]), 32'h7FFFE);
    chk("br_a1", 32'(a_log[1]), 32'h7FFFF);
    chk("br_a2", 32'(a_log[2]), 32'h00000);
    chk("br_a3", 32'(a_log[3]), 32'h00001);
    chk("br_contig", 32'(csn_cyc[3] - csn_cyc[0]), 32'd3);
    chk("br_rd_count", rd_log.size(), 32'd4);
    chk("br_d0", 32'(rd_log[0]), 32'h1111);
    chk("br_d1", 32'(rd_log[1]), 32'h2222);
    chk("br_d2", 32'(rd_log[2]), 32'h3333);
    chk("br_d3", 32'(rd_log[3]), 32'h4444);
    chk("br_rd_gapless", 32'(rd_cyc[3] - rd_cyc[0]), 32'd3);
    chk("br_busy_fall", 32'(fall_cyc - rd_cyc[3]), 32'd1);

    // write burst with a two-cycle stall after beat 0
    clear_logs();
    issue_req(1'b1, 19'h00100, 8'd2, 1'b0);
    wr_beat(16'h1000);
    wait_cycles(2);
    wr_beat(16'h1001);
    wr_beat(16'h1002);
    wait_cycles(4);
    chk("ws_pulses", a_log.size(), 32'd3);
    chk("ws_a0", 32'(a_log[0]), 32'h100);
    chk("ws_a1", 32'(a_log[1]), 32'h101);
    chk("ws_a2", 32'(a_log[2]), 32'h102);
    chk("ws_d1", 32'(din_log[1]), 32'h1001);
    chk("ws_d2", 32'(din_log[2]), 32'h1002);
    chk("ws_stall_gap", 32'(csn_cyc[1] - csn_cyc[0]), 32'd3);

    // reset in the middle of a read burst
    clear_logs();
    issue_req(1'b0, 19'h00200, 8'd7, 1'b0);
    n = 0;
    while (a_log.size() < 3 && n < 50) begin @(posedge clk); n++; end
    chk("rm_third_pulse_seen", {31'd0, (a_log.size() >= 3)}, 32'd1);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    clear_logs();
    @(negedge clk);
    chk("rm_csn", {31'd0, csn}, 32'd0);
    chk("rm_wen", {31'd0, wen}, 32'd0);
    chk("rm_a", 32'(a), 32'd0);
    chk("rm_din", 32'(din), 32'd0);
    chk("rm_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rm_rd_data", 32'(rd_data), 32'd0);
    chk("rm_busy", {31'd0, busy}, 32'd0);
    chk("rm_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rm_req_ready", {31'd0, req_ready}, 32'd1);
    wait_cycles(12);
    chk("rm_no_csn", a_log.size(), 32'd0);
    chk("rm_no_rd", rd_log.size(), 32'd0);

    // back-to-back requests with req_valid held
    clear_logs();
    issue_req(1'b1, 19'h00300, 8'd0, 1'b1);
    req_we = 1'b0; req_addr = 19'h00300; req_len = 8'd0;
    wr_beat(16'hBEEF);
    issue_req(1'b0, 19'h00300, 8'd0, 1'b0);
    wait_cycles(6);
    chk("bb_accepts", acc_cyc.size(), 32'd2);
    chk("bb_bubble", {31'd0, (acc_cyc[1] - acc_cyc[0] >= 2)}, 32'd1);
    chk("bb_ready_low", {31'd0, (rdylow_cyc.size() > 0 && rdylow_cyc[0] > acc_cyc[0] && rdylow_cyc[0] < acc_cyc[1])}, 32'd1);
    chk("bb_rd_data", 32'(rd_log[0]), 32'hBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Request-side controller that sits directly upstream of the sram block and is the only driver of its csn, wen, a and din pins.
- Accepts single or burst read/write requests over a valid/ready handshake.
- Sequences one SRAM access per clock and returns read data with a fixed, parameterised latency.
- Bursts auto-increment the address with wrap-around.

Parameters:
- AW, 19, SRAM address width (a[AW-1:0]).
- DW, 16, SRAM data width.
- RD_LAT, 1, cycles from a read access on the SRAM pins (csn=1, wen=0) to valid dout; legal range 0..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write burst, 0 = read burst.
- req_addr  in  AW  start address.
- req_len  in  8  beats minus one (0 = single beat, 255 = 256 beats).
- wr_valid  in  1  write data beat present.
- wr_ready  out  1  controller accepts the write beat.
- wr_data  in  DW  write data.
- rd_valid  out  1  read data beat valid (single-cycle pulse per beat, no back-pressure).
- rd_data  out  DW  read data.
- busy  out  1  request active or reads still in flight.
- csn  out  1  SRAM select; 1 = access this cycle.
- wen  out  1  SRAM write enable; 1 = write, 0 = read.
- a  out  AW  SRAM address.
- din  out  DW  SRAM write data.
- dout  in  DW  SRAM read data.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high (rst), and takes priority over every other event.
- Reset state:
  - State is IDLE.
  - csn=0, wen=0, a=0, din=0, rd_valid=0, rd_data=0, busy=0, wr_ready=0.
  - The read pipeline is flushed.
  - req_ready=1 from the first cycle after reset is released.
- Reset mid-burst: aborts the burst immediately. No further csn pulses occur, and no rd_valid is produced for beats already issued.
- SRAM pin outputs (csn, wen, a, din) are registered.
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - req_ready=1 (combinational from state).
  - On req_valid&&req_ready: latch addr, count=req_len and we; go to WRITE if req_we=1, else READ.
  - csn=0.
- WRITE:
  - wr_ready=1.
  - Each cycle with wr_valid=1: next cycle csn=1, wen=1, a=addr, din=wr_data; addr increments and count decrements.
  - Cycle with wr_valid=0: next cycle csn=0 (stall); addr and count hold.
  - When the beat with count==0 is accepted: go to IDLE. That beat still appears on the pins in the following cycle.
- READ:
  - One beat issued every cycle with no gaps: next cycle csn=1, wen=0, a=addr.
  - addr increments and count decrements each beat.
  - After the beat with count==0 is issued: go to DRAIN.
- DRAIN: wait until the read pipeline is empty, then go to IDLE. req_ready=0 throughout.
- Read return:
  - A beat on the pins in cycle T has dout valid at T+RD_LAT.
  - rd_data is registered from dout, with rd_valid=1 at cycle T+RD_LAT+1.
  - Tracked with a valid shift register of depth RD_LAT+1.
  - Beats return in issue order, one per cycle, with no gaps.
- Address arithmetic: modulo 2^AW; 2^AW-1 increments to 0 and the burst continues.
- busy = (state != IDLE) || (any read pipeline bit set) || csn.
- Bubble: at least one cycle of req_ready=0 separates consecutive requests. A new request is never accepted in the same cycle as the last beat.
- While in IDLE, wr_valid is ignored.

Test Plan:
- Single write: req_we=1, req_addr=0x00005, req_len=0, wr_data=0xA5A5 -> exactly one cycle with csn=1, wen=1, a=0x00005, din=0xA5A5; returns to IDLE with req_ready=1.
- Single read, RD_LAT=1: req_addr=0x00005 after the above write -> csn=1, wen=0, a=0x00005 in cycle T; rd_valid=1 with rd_data=0xA5A5 in cycle T+2, and no other rd_valid pulse.
- Burst read with wrap: req_addr=0x7FFFE, req_len=3 -> a sequence 0x7FFFE, 0x7FFFF, 0x00000, 0x00001 on 4 consecutive csn cycles; exactly 4 rd_valid pulses in order; busy falls one cycle after the last rd_valid.
- Write stall: burst len=2 (3 beats) with wr_valid low for 2 cycles between beat 0 and beat 1 -> csn low during the stall; addresses stay contiguous with no beat lost or duplicated.
- Reset mid-burst: read req_len=7, rst=1 for one cycle after the 3rd csn pulse -> no csn and no rd_valid after reset; all outputs 0; req_ready=1 the cycle after rst drops.
- Back-to-back: second req_valid held high from the cycle of the first acceptance -> it is accepted only after the first request reaches IDLE; at least one req_ready=0 cycle observed between acceptances.
